// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM state and owner
// encodings plus a counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    // Bits needed to hold values 0..n_values-1, never less than one.
    function automatic int cnt_width(input int n_values);
        return (n_values > 1) ? $clog2(n_values) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF fetch port, the DM load/store port and the memory-side
// port. The arbiter connects through the slave modport; the CPU/memory
// side (or a bench) uses the master modport.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // Instruction-fetch port
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    // Data-memory port
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_WIDTH-1:0] dm_rdata;

    // Unified memory port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// arb_latency_counter: loadable down-counter with a zero flag. The arbiter
// loads it when entering WAIT and leaves WAIT once it reads zero.
module arb_latency_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port (IF) and the data-memory port (DM). One access at a time runs
// IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP -> IDLE.
// Contention: DM wins until IF has lost STARVE_LIMIT times in a row.
// Build option: define ARB_ROUND_ROBIN_EN to resolve contention by
// alternating winners instead (IF wins the first contention after reset).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int               LAT_W    = cnt_width(MEM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

    arb_state_e            r_state;
    arb_owner_e            r_owner;
    logic                  r_we;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_if_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic                  r_dm_rvalid;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    logic                  w_if_win;
    logic                  w_dm_win;
    logic                  w_contend;
    logic                  w_lat_zero;

    assign w_contend = bus.if_req && bus.dm_req;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_e r_last_owner;

    // Remember who was granted last so contention alternates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner <= OWN_DM;
        end else if (w_if_win) begin
            r_last_owner <= OWN_IF;
        end else if (w_dm_win) begin
            r_last_owner <= OWN_DM;
        end
    end
`else
    localparam int STARVE_W = cnt_width(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve_cnt;

    // Count consecutive IF losses; any IF grant clears the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_if_win) begin
            r_starve_cnt <= '0;
        end else if (w_dm_win && w_contend) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end
`endif

    // Pick the winner; grants exist only while IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_if_win = 1'b0;
        w_dm_win = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_contend) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (r_last_owner == OWN_DM) begin
                    w_if_win = 1'b1;
                end else begin
                    w_dm_win = 1'b1;
                end
`else
                if (r_starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
                    w_dm_win = 1'b1;
                end else begin
                    w_if_win = 1'b1;
                end
`endif
            end else begin
                w_if_win = bus.if_req;
                w_dm_win = bus.dm_req;
            end
        end
    end

    arb_latency_counter #(
        .WIDTH      (LAT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (r_state == ST_ISSUE),
        .i_load_val (LAT_LOAD),
        .i_dec      (r_state == ST_WAIT),
        .o_zero     (w_lat_zero)
    );

    // Access FSM with registered memory strobes and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: response data flops are reset too, so outputs read 0 right after reset.
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop here sees pre-edge values.
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_if_win || w_dm_win) begin
                        r_owner     <= w_dm_win ? OWN_DM : OWN_IF;
                        r_we        <= w_dm_win && bus.dm_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_dm_win && bus.dm_we;
                        r_mem_addr  <= w_dm_win ? bus.dm_addr : bus.if_addr;
                        r_mem_wdata <= w_dm_win ? bus.dm_wdata : '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_lat_zero) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.mem_rdata;
                        end else begin
                            r_dm_rvalid <= 1'b1;
                            r_dm_rdata  <= r_we ? '0 : bus.mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = w_if_win;
    assign bus.dm_gnt    = w_dm_win;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rvalid = r_dm_rvalid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
